// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one-cold column drive, per-key debounce, and a
// press/release event FIFO with a valid/ready handshake plus a held-key bitmap.
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROWS-1:0]                row,
  output logic [COLS-1:0]                col,
  output logic [$clog2(ROWS*COLS)-1:0]   key_code,
  output logic                           key_press,
  output logic                           key_valid,
  input  logic                           key_ready,
  output logic [ROWS*COLS-1:0]           key_held,
  output logic                           overflow,
  input  logic                           ovf_clr
);
  localparam int KEYS      = ROWS * COLS;
  localparam int KW        = $clog2(KEYS);
  localparam int CW        = $clog2(SCAN_DIV);
  localparam int SW        = $clog2(COLS);
  localparam int DW        = $clog2(DEBOUNCE + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int NW        = AW + 1;
  localparam int SAMPLE_AT = SCAN_DIV / 2;
  localparam int EVAL_LO   = SAMPLE_AT + 1;

  logic [CW-1:0]                cnt_q, cnt_d;
  logic [SW-1:0]                col_sel_q, col_sel_d;
  logic [ROWS-1:0]              raw_q, raw_d;
  logic [KEYS-1:0]              held_q, held_d;
  logic [KEYS-1:0][DW-1:0]      dcnt_q, dcnt_d;
  logic [FIFO_DEPTH-1:0][KW:0]  mem_q, mem_d;
  logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]                count_q, count_d;
  logic                         valid_q, valid_d;
  logic                         ovf_q, ovf_d;

  logic          eval_en, eval_raw;
  int            eval_base;
  logic [KW-1:0] k_idx;
  logic          evt, evt_press;
  logic [KW-1:0] evt_code;
  logic          pop, full, push;

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    col_sel_d = col_sel_q;
    raw_d     = raw_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d     = '0;
      col_sel_d = (col_sel_q == SW'(COLS - 1)) ? '0 : col_sel_q + 1'b1;
    end
    // Rows are sampled mid-slot so the column drive has settled.
    if (cnt_q == CW'(SAMPLE_AT)) raw_d = ~row;
  end

  always_comb begin
    held_d    = held_q;
    dcnt_d    = dcnt_q;
    eval_en   = 1'b0;
    eval_raw  = 1'b0;
    eval_base = 0;
    evt       = 1'b0;
    evt_code  = '0;
    evt_press = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (cnt_q == CW'(EVAL_LO + r)) begin
        eval_en   = 1'b1;
        eval_raw  = raw_q[r];
        eval_base = r * COLS;
      end
    end
    k_idx = KW'(eval_base + int'(col_sel_q));
    // One key per cycle, so at most one event can compete for the FIFO.
    if (eval_en) begin
      if (eval_raw == held_q[k_idx]) begin
        dcnt_d[k_idx] = '0;
      end else if (dcnt_q[k_idx] == DW'(DEBOUNCE - 1)) begin
        dcnt_d[k_idx] = '0;
        held_d[k_idx] = eval_raw;
        evt           = 1'b1;
        evt_code      = k_idx;
        evt_press     = eval_raw;
      end else begin
        dcnt_d[k_idx] = dcnt_q[k_idx] + 1'b1;
      end
    end
  end

  always_comb begin
    pop     = valid_q && key_ready;
    full    = (count_q == NW'(FIFO_DEPTH));
    push    = evt && (!full || pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) begin
      mem_d[wr_q] = {evt_code, evt_press};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (evt && !push)  ovf_d = 1'b1;
    else if (ovf_clr)  ovf_d = 1'b0;
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      col_sel_q <= '0;
      raw_q     <= '0;
      held_q    <= '0;
      dcnt_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      col_sel_q <= col_sel_d;
      raw_q     <= raw_d;
      held_q    <= held_d;
      dcnt_q    <= dcnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head fields read as zero while empty so they match the reset state.
  assign col       = ~(COLS'(1) << col_sel_q);
  assign key_code  = valid_q ? mem_q[rd_q][KW:1] : '0;
  assign key_press = valid_q ? mem_q[rd_q][0] : 1'b0;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: physical key matrix model, time-based reference
// model feeding an event queue, and a negedge monitor that checks every cycle.
module tb_keypad_scan_fifo;
  localparam int S  = 16;
  localparam int DB = 3;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_press;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic [15:0] key_held;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  logic [15:0] pressed = 16'h0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          t = 0;
  logic [15:0] m_held = 16'h0;
  int          m_dc[16];
  logic [3:0]  m_samp = 4'h0;
  logic        m_ovf = 1'b0;
  int          m_occ = 0;
  int          mq[$];

  keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(S), .DEBOUNCE(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
    .key_press(key_press), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key shorts its row to its column line.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per clock, derived from elapsed cycles since reset.
  always @(posedge clk) begin
    if (!rst) begin
      t = 0; m_held = 16'h0; m_samp = 4'h0; m_ovf = 1'b0; m_occ = 0;
      for (int k = 0; k < 16; k++) m_dc[k] = 0;
      mq.delete();
    end else begin
      int cnt, c, k, r;
      bit ev, pp;
      cnt = t % S;
      c   = (t / S) % 4;
      ev  = 0;
      k   = 0;
      if (cnt == S/2)
        for (int rr = 0; rr < 4; rr++) m_samp[rr] = pressed[rr*4+c];
      if (cnt >= S/2+1 && cnt < S/2+1+4) begin
        r = cnt - (S/2+1);
        k = r*4 + c;
        if (m_samp[r] == m_held[k]) m_dc[k] = 0;
        else begin
          m_dc[k]++;
          if (m_dc[k] == DB) begin
            m_held[k] = ~m_held[k];
            m_dc[k] = 0;
            ev = 1;
          end
        end
      end
      pp = key_ready && (m_occ > 0);
      if (ev && (m_occ < FD || pp)) begin
        mq.push_back(k*2 + int'(m_held[k]));
        m_occ++;
      end else if (ev) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (pp) m_occ--;
      t++;
    end
  end

  // Monitor: compares DUT against model and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    if (rst) begin
      logic [3:0] ec;
      int e;
      ec = ~(4'b0001 << ((t / S) % 4));
      chk("col", 32'(col), 32'(ec));
      chk("key_valid", 32'(key_valid), 32'(m_occ > 0));
      chk("key_held", 32'(key_held), 32'(m_held));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (key_valid && key_ready) begin
        if (mq.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
        else begin
          e = mq.pop_front();
          chk("key_code", 32'(key_code), 32'(e / 2));
          chk("key_press", 32'(key_press), 32'(e % 2));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_col", 32'(col), 32'(4'b1110));
    chk("rst_valid", 32'(key_valid), 32'(0));
    chk("rst_held", 32'(key_held), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_code", 32'(key_code), 32'(0));
    chk("rst_press", 32'(key_press), 32'(0));
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    cycles(2);
    #2 rst = 1'b1;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
  endtask

  initial begin
    int n, pr;
    bit drained;
    for (int k = 0; k < 16; k++) m_dc[k] = 0;

    // Reset mid-cycle and column rotation
    cycles(2);
    pulse_reset();
    @(posedge clk); #1;
    check_reset_outputs();
    cycles(15);
    chk("col_after_16", 32'(col), 32'(4'b1101));
    cycles(16);
    chk("col_after_32", 32'(col), 32'(4'b1011));

    // Steady press of key 6, then release
    pressed = 16'h0040;
    cycles(4*64);
    chk("held6_press", 32'(key_held[6]), 32'(1));
    cycles(2*64);
    pressed = 16'h0000;
    cycles(4*64);
    chk("held6_release", 32'(key_held[6]), 32'(0));

    // Bouncing key 6: 2 frames on, 1 off, 2 on, then off
    pressed = 16'h0040; cycles(2*64);
    pressed = 16'h0000; cycles(64);
    pressed = 16'h0040; cycles(2*64);
    pressed = 16'h0000; cycles(64);
    chk("bounce_held6", 32'(key_held[6]), 32'(0));
    chk("bounce_no_event", 32'(key_valid), 32'(0));

    // Randomised key patterns, ready and clear activity
    for (int p = 0; p < 20; p++) begin
      if (p % 5 == 4) pressed = 16'h0;
      else begin
        pressed = 16'(1 << $urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) pressed = pressed | 16'(1 << $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) pressed = pressed | 16'(1 << $urandom_range(0, 15));
      end
      pr = $urandom_range(1, 4);
      n  = 64 * $urandom_range(1, 5) + $urandom_range(0, 63);
      for (int i = 0; i < n; i++) begin
        key_ready = ($urandom_range(0, 3) < pr);
        ovf_clr   = ($urandom_range(0, 40) == 0);
        cycles(1);
      end
    end

    // Clean state before the overflow scenario
    key_ready = 1'b1; ovf_clr = 1'b0; pressed = 16'h0;
    cycles(4*64);
    pulse_clr();
    chk("pre_ovf_clear", 32'(overflow), 32'(0));

    // Five presses into a four-entry FIFO with the consumer stalled
    key_ready = 1'b0;
    pressed = 16'h002F;
    cycles(4*64);
    chk("ovf_set", 32'(overflow), 32'(1));
    chk("ovf_held", 32'(key_held), 32'(16'h002F));
    chk("ovf_valid", 32'(key_valid), 32'(1));
    key_ready = 1'b1;
    drained = 0;
    for (int i = 0; i < 20 && !drained; i++) begin
      cycles(1);
      if (!key_valid) drained = 1;
    end
    chk("drain_done", 32'(drained), 32'(1));
    chk("ovf_sticky", 32'(overflow), 32'(1));
    pulse_clr();
    chk("ovf_cleared", 32'(overflow), 32'(0));
    pressed = 16'h0;
    cycles(4*64);

    // Reset while key 6 is held, at scan count 9
    pressed = 16'h0040;
    cycles(4*64);
    chk("pre_rst_held6", 32'(key_held[6]), 32'(1));
    n = 0;
    while ((t % S) != 9 && n < 64) begin cycles(1); n++; end
    chk("found_cnt9", 32'(t % S), 32'(9));
    pulse_reset();
    cycles(4*64);
    chk("rereport_held6", 32'(key_held[6]), 32'(1));

    pressed = 16'h0;
    cycles(4*64);
    chk("queue_empty_end", 32'(mq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
